// File: rtl/pc_display_scanner.sv
// Time-multiplexed scanner driving four pipeline-stage PC segment codes onto a shared 4-digit display.
// Optional macro SS_SNAPSHOT_EN latches all four codes at the start of each frame for a coherent snapshot.
module pc_display_scanner #(
  parameter int         CLK_DIV      = 50000,
  parameter int         BLANK_CYCLES = 16,
  parameter logic [6:0] SEG_OFF      = 7'h7F
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] ifid_seg,
  input  logic [6:0] idexe_seg,
  input  logic [6:0] exemem_seg,
  input  logic [6:0] memwb_seg,
  output logic [6:0] seg_out,
  output logic [3:0] digit_en,
  output logic       frame_tick
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  typedef enum logic {BLANK, DISPLAY} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         idx_reg, idx_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [BLANK_W-1:0] blank_reg, blank_next;
  logic               frame_next;
  logic [6:0]         seg_next;
  logic [3:0]         en_next;

  // Index 0 is the rightmost digit, which shows the MEM/WB stage.
  logic [3:0][6:0] live_codes;
  logic [3:0][6:0] slot_codes;
  assign live_codes = {ifid_seg, idexe_seg, exemem_seg, memwb_seg};

`ifdef SS_SNAPSHOT_EN
  logic [3:0][6:0] shadow_reg, shadow_next;
  logic            enter_first;

  // Entering idx0's slot either from blanking or directly from the idx3 slot.
  assign enter_first = (state_next == DISPLAY) && (idx_next == 2'd0) &&
                       ((state_reg == BLANK) || (div_reg == DIV_LAST));
  assign shadow_next = enter_first ? live_codes : shadow_reg;
  assign slot_codes  = shadow_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_reg <= {4{SEG_OFF}};
    end else begin
      shadow_reg <= shadow_next;
    end
  end
`else
  assign slot_codes = live_codes;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    div_next   = div_reg;
    blank_next = blank_reg;
    frame_next = 1'b0;
    case (state_reg)
      BLANK: begin
        if (NO_BLANK || (blank_reg == BLANK_LAST)) begin
          state_next = DISPLAY;
          blank_next = '0;
        end else begin
          blank_next = blank_reg + BLANK_W'(1);
        end
      end
      DISPLAY: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          idx_next   = idx_reg + 2'd1;
          state_next = NO_BLANK ? DISPLAY : BLANK;
          frame_next = (idx_reg == 2'd3);
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      default: state_next = BLANK;
    endcase
  end

  // Outputs are decoded from the next state so the pins line up with the state they describe.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign en_next[gi] = ~((state_next == DISPLAY) && (idx_next == 2'(gi)));
  end
  assign seg_next = (state_next == DISPLAY) ? slot_codes[idx_next] : SEG_OFF;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= BLANK;
      idx_reg    <= 2'd0;
      div_reg    <= '0;
      blank_reg  <= '0;
      seg_out    <= SEG_OFF;
      digit_en   <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      div_reg    <= div_next;
      blank_reg  <= blank_next;
      seg_out    <= seg_next;
      digit_en   <= en_next;
      frame_tick <= frame_next;
    end
  end

endmodule

// File: tb/tb_pc_display_scanner.sv
// Self-checking bench: two scanner instances (CLK_DIV=4/BLANK=2 and CLK_DIV=1/BLANK=0)
// compared every cycle against a frame-position model, plus literal waveform checks.
module tb_pc_display_scanner;

`ifdef SS_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] ifid_seg, idexe_seg, exemem_seg, memwb_seg;
  logic [6:0] seg_a, seg_b;
  logic [3:0] en_a, en_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int errors = 0;
  int t_cnt  = 0;
  bit armed  = 1'b0;

  logic [3:0][6:0] prev_codes;
  logic [3:0][6:0] snap_a, snap_b;

  always #5 clock = ~clock;

  pc_display_scanner #(.CLK_DIV(4), .BLANK_CYCLES(2), .SEG_OFF(7'h7F)) dut_a (
    .clock(clock), .reset(reset),
    .ifid_seg(ifid_seg), .idexe_seg(idexe_seg), .exemem_seg(exemem_seg), .memwb_seg(memwb_seg),
    .seg_out(seg_a), .digit_en(en_a), .frame_tick(tick_a)
  );

  pc_display_scanner #(.CLK_DIV(1), .BLANK_CYCLES(0), .SEG_OFF(7'h7F)) dut_b (
    .clock(clock), .reset(reset),
    .ifid_seg(ifid_seg), .idexe_seg(idexe_seg), .exemem_seg(exemem_seg), .memwb_seg(memwb_seg),
    .seg_out(seg_b), .digit_en(en_b), .frame_tick(tick_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t_cnt);
    end
  endtask

  // Position within the frame: with no blanking the post-reset cycle still shows blank,
  // so the scan is shifted by one cycle.
  function automatic logic [11:0] model_out(input int d, input int b, input int t,
                                            input logic [3:0][6:0] codes);
    int lead, period, p, slot, off;
    logic [3:0] en;
    logic [6:0] seg;
    logic tick;
    lead = (b == 0) ? 1 : 0;
    period = 4 * (d + b);
    en = 4'hF; seg = 7'h7F; tick = 1'b0;
    if (t >= lead) begin
      p = (t - lead) % period;
      slot = p / (d + b);
      off = p % (d + b);
      if (off >= b) begin
        en[slot] = 1'b0;
        seg = codes[slot];
      end
      tick = (p == 0) && (t - lead >= period);
    end
    return {tick, en, seg};
  endfunction

  function automatic bit frame_start(input int d, input int b, input int t);
    int lead;
    lead = (b == 0) ? 1 : 0;
    return (t >= lead) && (((t - lead) % (4 * (d + b))) == b);
  endfunction

  always @(posedge clock) begin
    prev_codes[0] = memwb_seg;
    prev_codes[1] = exemem_seg;
    prev_codes[2] = idexe_seg;
    prev_codes[3] = ifid_seg;
    if (reset) begin
      t_cnt = 0;
      armed = 1'b1;
      snap_a = {4{7'h7F}};
      snap_b = {4{7'h7F}};
    end else begin
      t_cnt++;
      if (frame_start(4, 2, t_cnt)) snap_a = prev_codes;
      if (frame_start(1, 0, t_cnt)) snap_b = prev_codes;
    end
  end

  always @(negedge clock) begin
    logic [11:0] ea, eb;
    if (armed) begin
      ea = model_out(4, 2, t_cnt, SNAP ? snap_a : prev_codes);
      eb = model_out(1, 0, t_cnt, SNAP ? snap_b : prev_codes);
      check("a_seg", {1'b0, seg_a}, {1'b0, ea[6:0]});
      check("a_en", {4'b0, en_a}, {4'b0, ea[10:7]});
      check("a_tick", {7'b0, tick_a}, {7'b0, ea[11]});
      check("b_seg", {1'b0, seg_b}, {1'b0, eb[6:0]});
      check("b_en", {4'b0, en_b}, {4'b0, eb[10:7]});
      check("b_tick", {7'b0, tick_b}, {7'b0, eb[11]});
      check("a_onehot", 8'($countones(~en_a) <= 1), 8'd1);
      check("b_onehot", 8'($countones(~en_b) <= 1), 8'd1);
    end
  end

  function automatic logic [6:0] seg_for(input logic [3:0] en);
    case (en)
      4'b1110: return 7'h40;
      4'b1101: return 7'h79;
      4'b1011: return 7'h24;
      4'b0111: return 7'h30;
      default: return 7'h7F;
    endcase
  endfunction

  logic [3:0] pat_a [24] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                             4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF, 4'hB, 4'hB,
                             4'hB, 4'hB, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};
  logic [3:0] pat_b [9]  = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    int found;
    reset = 1'b1;
    memwb_seg = 7'h40; exemem_seg = 7'h79; idexe_seg = 7'h24; ifid_seg = 7'h30;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    $display("reset released, scanning first frame");

    for (int k = 0; k < 25; k++) begin
      if (k > 0) @(negedge clock);
      if (k < 24) begin
        check("lit_a_en", {4'b0, en_a}, {4'b0, pat_a[k]});
        check("lit_a_seg", {1'b0, seg_a}, {1'b0, seg_for(pat_a[k])});
        check("lit_a_tick", {7'b0, tick_a}, 8'd0);
      end else begin
        check("lit_a_wrap_tick", {7'b0, tick_a}, 8'd1);
        check("lit_a_wrap_en", {4'b0, en_a}, 8'h0F);
      end
      if (k < 9) begin
        check("lit_b_en", {4'b0, en_b}, {4'b0, pat_b[k]});
        check("lit_b_seg", {1'b0, seg_b}, {1'b0, seg_for(pat_b[k])});
        check("lit_b_tick", {7'b0, tick_b}, (k == 5) ? 8'd1 : 8'd0);
      end
    end

    // Second frame: digit 0 lit for t=26..29; change memwb during its third cycle.
    repeat (4) @(negedge clock);
    check("live_before", {1'b0, seg_a}, 8'h40);
    memwb_seg = 7'h12;
    $display("memwb_seg changed 40 -> 12 during digit 0");
    @(negedge clock);
    check("live_after_en", {4'b0, en_a}, 8'h0E);
    check("live_after_seg", {1'b0, seg_a}, SNAP ? 8'h40 : 8'h12);

    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clock);
      if (en_a == 4'b1011) found = 1;
    end
    check("wait_digit2", 8'(found), 8'd1);
    reset = 1'b1;
    $display("reset asserted during digit 2");
    @(negedge clock);
    reset = 1'b0;
    check("midrst_en", {4'b0, en_a}, 8'h0F);
    check("midrst_seg", {1'b0, seg_a}, 8'h7F);
    check("midrst_tick", {7'b0, tick_a}, 8'd0);
    @(negedge clock);
    check("midrst_blank", {4'b0, en_a}, 8'h0F);
    @(negedge clock);
    check("midrst_restart", {4'b0, en_a}, 8'h0E);

    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        $display("random reset at cycle %0d", c);
      end
      if ($urandom_range(0, 3) == 0) begin
        memwb_seg  = 7'($urandom);
        exemem_seg = 7'($urandom);
        idexe_seg  = 7'($urandom);
        ifid_seg   = 7'($urandom);
      end
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
